// File: rtl/bp_update_scheduler.sv
// Training-update scheduler for the gselect PHT/BTB: a dual-enqueue FIFO drained over one table write port,
// plus the post-reset/flush table clear sweep. Optional statistics counters: define BP_SCHED_STATS_EN.
module bp_update_scheduler #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       upd0_valid,
    input  logic [ADDR_W-1:0]          upd0_pc,
    input  logic [ADDR_W-1:0]          upd0_target,
    input  logic                       upd0_isbranch,
    input  logic                       upd0_taken,
    input  logic                       upd1_valid,
    input  logic [ADDR_W-1:0]          upd1_pc,
    input  logic [ADDR_W-1:0]          upd1_target,
    input  logic                       upd1_isbranch,
    input  logic                       upd1_taken,
    input  logic                       flush,
    output logic                       upd_ready,
    output logic                       tbl_wr_valid,
    input  logic                       tbl_wr_ready,
    output logic                       tbl_wr_init,
    output logic [IDX_W-1:0]           tbl_wr_idx,
    output logic [ADDR_W-1:0]          tbl_wr_pc,
    output logic [ADDR_W-1:0]          tbl_wr_target,
    output logic                       tbl_wr_isbranch,
    output logic                       tbl_wr_taken,
    output logic                       init_done,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           stat_accepted,
    output logic [CNT_W-1:0]           stat_dropped
);
    // Table write handshake: a write transfers on a cycle where tbl_wr_valid & tbl_wr_ready; while valid is
    // high without ready, idx and payload hold. Valid only drops without a transfer on flush or reset.
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        logic              isbranch;
        logic              taken;
    } entry_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_FW-1:0]  count_q, count_d;
    logic               upd_ready_q, upd_ready_d;

    logic               flush_act, push0, push1, pop;
    logic [CNT_FW-1:0]  free_w;
    logic [PTR_W-1:0]   wr1_ptr;
    entry_t             head, new0, new1;

    assign flush_act = flush && (state_q != S_IDLE);
    assign free_w    = CNT_FW'(DEPTH) - count_q;
    // Space is judged on the registered count only, so a same-cycle pop never makes room.
    assign push0     = (state_q == S_RUN) && !flush_act && upd0_valid && (free_w >= CNT_FW'(1));
    assign push1     = (state_q == S_RUN) && !flush_act && upd1_valid &&
                       (free_w >= (push0 ? CNT_FW'(2) : CNT_FW'(1)));
    assign pop       = (state_q == S_RUN) && !flush_act && (count_q != '0) && tbl_wr_ready;
    assign wr1_ptr   = push0 ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign head      = mem_q[rd_ptr_q];
    assign new0      = '{pc: upd0_pc, target: upd0_target, isbranch: upd0_isbranch, taken: upd0_taken};
    assign new1      = '{pc: upd1_pc, target: upd1_target, isbranch: upd1_isbranch, taken: upd1_taken};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: state_d = S_INIT;
            S_INIT: begin
                if (tbl_wr_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '1) state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
                wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
                count_d  = count_q + CNT_FW'(push0) + CNT_FW'(push1) - CNT_FW'(pop);
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_act) begin
            state_d  = S_INIT;
            idx_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
        upd_ready_d = (state_d == S_RUN) && ((CNT_FW'(DEPTH) - count_d) >= CNT_FW'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            upd_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            upd_ready_q <= upd_ready_d;
            if (push0) mem_q[wr_ptr_q] <= new0;
            if (push1) mem_q[wr1_ptr]  <= new1;
        end
    end

    // Sweep writes carry a zero payload; outside RUN the payload is forced to zero.
    assign tbl_wr_valid    = (state_q == S_INIT) || ((state_q == S_RUN) && (count_q != '0));
    assign tbl_wr_init     = (state_q == S_INIT);
    assign tbl_wr_idx      = (state_q == S_INIT) ? idx_q :
                             (state_q == S_RUN)  ? head.pc[IDX_W+1:2] : '0;
    assign tbl_wr_pc       = (state_q == S_RUN) ? head.pc       : '0;
    assign tbl_wr_target   = (state_q == S_RUN) ? head.target   : '0;
    assign tbl_wr_isbranch = (state_q == S_RUN) && head.isbranch;
    assign tbl_wr_taken    = (state_q == S_RUN) && head.taken;
    assign init_done       = (state_q == S_RUN);
    assign fifo_count      = count_q;
    assign upd_ready       = upd_ready_q;

`ifdef BP_SCHED_STATS_EN
    localparam int CNT_W1 = CNT_W + 1;
    logic [CNT_W-1:0] acc_q, drop_q;
    logic [1:0]       n_acc, n_drop;
    logic [CNT_W:0]   acc_sum, drop_sum;

    assign n_acc    = {1'b0, push0} + {1'b0, push1};
    assign n_drop   = {1'b0, upd0_valid && !push0} + {1'b0, upd1_valid && !push1};
    assign acc_sum  = {1'b0, acc_q}  + CNT_W1'(n_acc);
    assign drop_sum = {1'b0, drop_q} + CNT_W1'(n_drop);

    // Saturating; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            drop_q <= '0;
        end else begin
            acc_q  <= acc_sum[CNT_W]  ? '1 : acc_sum[CNT_W-1:0];
            drop_q <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    assign stat_accepted = acc_q;
    assign stat_dropped  = drop_q;
`else
    assign stat_accepted = '0;
    assign stat_dropped  = '0;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed + randomised bench for bp_update_scheduler (IDX_W=3, DEPTH=8) with an expected-entry queue.
module tb_bp_update_scheduler;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int W      = 2 * ADDR_W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              upd0_valid, upd0_isbranch, upd0_taken;
  logic [ADDR_W-1:0] upd0_pc, upd0_target;
  logic              upd1_valid, upd1_isbranch, upd1_taken;
  logic [ADDR_W-1:0] upd1_pc, upd1_target;
  logic              flush, upd_ready, tbl_wr_valid, tbl_wr_ready, tbl_wr_init;
  logic [IDX_W-1:0]  tbl_wr_idx;
  logic [ADDR_W-1:0] tbl_wr_pc, tbl_wr_target;
  logic              tbl_wr_isbranch, tbl_wr_taken, init_done;
  logic [3:0]        fifo_count;
  logic [CNT_W-1:0]  stat_accepted, stat_dropped;

  bp_update_scheduler #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_target(upd0_target),
    .upd0_isbranch(upd0_isbranch), .upd0_taken(upd0_taken),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_target(upd1_target),
    .upd1_isbranch(upd1_isbranch), .upd1_taken(upd1_taken),
    .flush(flush), .upd_ready(upd_ready),
    .tbl_wr_valid(tbl_wr_valid), .tbl_wr_ready(tbl_wr_ready), .tbl_wr_init(tbl_wr_init),
    .tbl_wr_idx(tbl_wr_idx), .tbl_wr_pc(tbl_wr_pc), .tbl_wr_target(tbl_wr_target),
    .tbl_wr_isbranch(tbl_wr_isbranch), .tbl_wr_taken(tbl_wr_taken),
    .init_done(init_done), .fifo_count(fifo_count),
    .stat_accepted(stat_accepted), .stat_dropped(stat_dropped)
  );

  // scoreboard and reference state (0 = IDLE, 1 = INIT, 2 = RUN)
  logic [W-1:0]     exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               m_state;
  logic [IDX_W-1:0] m_idx;
  int               exp_acc, exp_drop;

  function automatic int stat_exp(input int v);
`ifdef BP_SCHED_STATS_EN
    stat_exp = v;
`else
    stat_exp = v * 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_state  = 0;
    m_idx    = '0;
    exp_acc  = 0;
    exp_drop = 0;
  endtask

  // driver tasks
  task automatic set_upd(input logic v0, input logic [ADDR_W-1:0] pc0, input logic [ADDR_W-1:0] tg0,
                         input logic b0, input logic t0,
                         input logic v1, input logic [ADDR_W-1:0] pc1, input logic [ADDR_W-1:0] tg1,
                         input logic b1, input logic t1);
    upd0_valid = v0; upd0_pc = pc0; upd0_target = tg0; upd0_isbranch = b0; upd0_taken = t0;
    upd1_valid = v1; upd1_pc = pc1; upd1_target = tg1; upd1_isbranch = b1; upd1_taken = t1;
  endtask

  task automatic idle_upd();
    set_upd(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_upd(input int pct);
    set_upd($urandom_range(0, 99) < pct, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < pct, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, tbl_wr_valid, 0);
    chk({tag, "_init"}, tbl_wr_init, 0);
    chk({tag, "_idx"}, tbl_wr_idx, 0);
    chk({tag, "_pc"}, tbl_wr_pc, 0);
    chk({tag, "_tgt"}, tbl_wr_target, 0);
    chk({tag, "_bt"}, {tbl_wr_isbranch, tbl_wr_taken}, 0);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_rdy"}, upd_ready, 0);
    chk({tag, "_cnt"}, fifo_count, 0);
    chk({tag, "_acc"}, stat_accepted, 0);
    chk({tag, "_drop"}, stat_dropped, 0);
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic step();
    logic [W-1:0]      h;
    logic [ADDR_W-1:0] hpc;
    int                sz;
    logic              fl, p0, p1;
    #1;
    if (!rst_n) m_reset();
    sz = exp_q.size();
    chk("wr_valid", tbl_wr_valid, (m_state == 1) || (m_state == 2 && sz > 0));
    chk("wr_init", tbl_wr_init, m_state == 1);
    chk("init_done", init_done, m_state == 2);
    chk("fifo_count", fifo_count, sz);
    chk("upd_ready", upd_ready, (m_state == 2) && (DEPTH - sz >= 2));
    chk("stat_accepted", stat_accepted, stat_exp(exp_acc));
    chk("stat_dropped", stat_dropped, stat_exp(exp_drop));
    if (m_state == 2 && sz > 0) begin
      h   = exp_q[0];
      hpc = h[W-1:ADDR_W+2];
      chk("head_pc", tbl_wr_pc, hpc);
      chk("head_tgt", tbl_wr_target, h[ADDR_W+1:2]);
      chk("head_bt", {tbl_wr_isbranch, tbl_wr_taken}, h[1:0]);
      chk("head_idx", tbl_wr_idx, hpc[IDX_W+1:2]);
    end else if (m_state != 2) begin
      chk("sweep_idx", tbl_wr_idx, (m_state == 1) ? m_idx : 3'd0);
      chk("sweep_payload", {tbl_wr_pc, tbl_wr_target[1:0], tbl_wr_isbranch, tbl_wr_taken}, 0);
    end
    if (rst_n) begin
      fl = flush && (m_state != 0);
      p0 = !fl && (m_state == 2) && upd0_valid && (DEPTH - sz >= 1);
      p1 = !fl && (m_state == 2) && upd1_valid && (DEPTH - sz >= 1 + int'(p0));
      exp_acc  += int'(p0) + int'(p1);
      exp_drop += int'(upd0_valid && !p0) + int'(upd1_valid && !p1);
      if (fl) begin
        exp_q.delete();
        m_state = 1;
        m_idx   = '0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (tbl_wr_ready) begin
          if (m_idx == 3'd7) m_state = 2;
          m_idx = m_idx + 3'd1;
        end
      end else begin
        if (tbl_wr_ready && sz > 0) void'(exp_q.pop_front());
        if (p0) exp_q.push_back({upd0_pc, upd0_target, upd0_isbranch, upd0_taken});
        if (p1) exp_q.push_back({upd1_pc, upd1_target, upd1_isbranch, upd1_taken});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; tbl_wr_ready = 1'b1;
    idle_upd();
    m_reset();
    step(); step();
    check_zero("reset");
    rst_n = 1'b1;

    // sweep after reset; updates offered during IDLE/INIT are dropped
    rand_upd(60);
    for (int i = 0; i < 8; i++) step();
    chk("init_done_cycle9", init_done, 0);
    idle_upd();
    step();
    chk("init_done_cycle10", init_done, 1);

    // dual update in one cycle, drained on consecutive cycles
    set_upd(1'b1, 32'h40, 32'h1000, 1'b1, 1'b1, 1'b1, 32'h80, 32'h2000, 1'b1, 1'b0);
    step();
    idle_upd();
    chk("dual_head_pc", tbl_wr_pc, 32'h40);
    step();
    chk("dual_second_pc", tbl_wr_pc, 32'h80);
    step(); step();

    // fill with ready low; fifth pair is dropped
    tbl_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_upd(100);
      step();
    end
    idle_upd();
    chk("full_count", fifo_count, 8);
    chk("full_upd_ready", upd_ready, 0);
    step();

    // head pc=0x44 under toggling ready
    tbl_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    set_upd(1'b1, 32'h44, 32'h4400, 1'b1, 1'b1, 1'b1, 32'h48, 32'h4800, 1'b1, 1'b0);
    tbl_wr_ready = 1'b0;
    step();
    idle_upd();
    for (int i = 0; i < 16; i++) begin
      tbl_wr_ready = 1'($urandom_range(0, 1));
      step();
    end
    tbl_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // flush at count 5 with concurrent updates
    tbl_wr_ready = 1'b0;
    rand_upd(100); step();
    rand_upd(100); step();
    set_upd(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); step();
    chk("pre_flush_count", fifo_count, 5);
    flush = 1'b1;
    tbl_wr_ready = 1'b1;
    rand_upd(100);
    step();
    flush = 1'b0;
    idle_upd();
    chk("post_flush_count", fifo_count, 0);
    chk("post_flush_idx", tbl_wr_idx, 0);
    for (int i = 0; i < 3; i++) step();

    // asynchronous reset mid-sweep at idx 3
    chk("mid_sweep_idx", tbl_wr_idx, 3);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    m_reset();
    step();
    rst_n = 1'b1;
    step();
    chk("restart_idx", tbl_wr_idx, 0);
    for (int i = 0; i < 10; i++) begin
      tbl_wr_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      rand_upd(55);
      tbl_wr_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    flush = 1'b0;
    idle_upd();
    tbl_wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
